coreapb3_arbiter: RTL
=====================

# coreapb3_arbiter

Two-initiator APB3 arbiter that shares one APB3 target between initiator ports APBI0 and APBI1 on a per-transfer basis. It replaces static mux selection where both masters are live simultaneously: it grants one initiator per transfer, regenerates a protocol-correct setup/access sequence on the target, and stalls the losing initiator with PREADY low. An optional watchdog terminates hung target transfers with PSLVERR.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- ARB_MODE, 1, 0 = fixed priority (APBI0 wins), 1 = round-robin
- TIMEOUT, 0, maximum ACCESS cycles before forced error completion; 0 disables the watchdog; range 0..65535
- PCLK  in  1  single clock; all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- APBI0_PSEL, APBI0_PWRITE, APBI0_PENABLE  in  1  initiator 0 control
- APBI0_PADDR  in  ADDR_WIDTH;  APBI0_PWDATA  in  DATA_WIDTH
- APBI0_PREADY, APBI0_PSLVERR  out  1;  APBI0_PRDATA  out  DATA_WIDTH
- APBI1_*: same set as APBI0_*, for initiator 1
- APBT_PSEL, APBT_PWRITE, APBT_PENABLE  out  1  target control
- APBT_PADDR  out  ADDR_WIDTH;  APBT_PWDATA  out  DATA_WIDTH
- APBT_PREADY, APBT_PSLVERR  in  1;  APBT_PRDATA  in  DATA_WIDTH
- ARB_GNT  out  2  one-hot current grant ({I1,I0}); 00 when idle
- ARB_TIMEOUT  out  1  one-cycle pulse on each watchdog-forced completion

## Operation
- FSM states: IDLE, SETUP, ACCESS. Registers: state, grant index GNT, last-grant pointer LAST, 16-bit watchdog counter WCNT.
- Request: reqN = APBIN_PSEL. PENABLE is not used for the request, so an initiator stalled in its access phase still requests.
- IDLE:
  - no request: remain in IDLE.
  - one request: grant it, go to SETUP.
  - both requesting: ARB_MODE=0 grants I0; ARB_MODE=1 grants the initiator other than LAST.
- SETUP: APBT_PSEL=1, APBT_PENABLE=0; WCNT cleared; go to ACCESS.
- ACCESS:
  - APBT_PSEL=1, APBT_PENABLE=1; WCNT increments each cycle APBT_PREADY=0.
  - APBT_PREADY=1: completion. Route PREADY=1 with target PRDATA/PSLVERR to the granted initiator; LAST<=GNT; go to IDLE.
  - TIMEOUT!=0 and WCNT==TIMEOUT-1 with APBT_PREADY=0: forced completion. Granted initiator sees PREADY=1, PSLVERR=1, PRDATA=0; ARB_TIMEOUT=1; LAST<=GNT; go to IDLE. Target PSEL drops the next cycle.
- APBT_PADDR/PWDATA/PWRITE: combinational mux from the GNT initiator (APB guarantees stability while PSEL is held). In IDLE they mux from I0.
- Initiator outputs:
  - non-granted initiator: PREADY=0, PRDATA=0, PSLVERR=0.
  - granted initiator: PREADY/PRDATA/PSLVERR pass through only in ACCESS, and are 0 in IDLE and SETUP.
- No back-to-back grant: every completion returns to IDLE. Minimum 3 cycles per transfer (IDLE, SETUP, ACCESS) with a zero-wait target.
- An initiator that drops PSEL while stalled (protocol violation) loses nothing. If already granted, the transfer still completes on the target; the result is discarded.

## Timing
- Reset (PRESET sampled high): state=IDLE, GNT=0, LAST=1 (so I0 wins the first tie), WCNT=0. All outputs low/zero the same cycle state is IDLE: APBT_PSEL, APBT_PENABLE, ARB_GNT, ARB_TIMEOUT, all APBIx_PREADY/PSLVERR/PRDATA.
- Reset mid-transfer: target PSEL/PENABLE drop on the next edge. The in-flight initiator never receives PREADY.
- Latency: request sampled in IDLE at cycle t; target setup at t+1; target access from t+2; initiator PREADY in the same cycle as APBT_PREADY (combinational).
- Simultaneous request with completion: a pending request is evaluated only in the IDLE cycle after completion.
- Watchdog: forced completion in ACCESS cycle number TIMEOUT (1-based). TIMEOUT=1 forces completion on the first ACCESS cycle if APBT_PREADY=0.

## Test plan
- Single I0 write, ADDR=0x10, WDATA=0xA5A5A5A5, zero-wait target -> APBT_PSEL high 2 cycles, PENABLE high 1 cycle, APBI0_PREADY=1 once; APBI1 outputs stay 0.
- I0 and I1 both request from reset, ARB_MODE=1, continuous requests -> grant order I0, I1, I0, I1; each transfer 3 cycles; loser's PREADY=0 throughout.
- Same stimulus, ARB_MODE=0 -> I0 granted every time; I1 starves while I0 keeps PSEL high.
- I1 read with target 4 wait states, PRDATA=0x12345678, PSLVERR=1 -> APBI1_PREADY=1 on the 5th ACCESS cycle with PRDATA=0x12345678, PSLVERR=1.
- TIMEOUT=8, target never ready -> forced completion on ACCESS cycle 8: APBI0_PSLVERR=1, PRDATA=0, ARB_TIMEOUT pulse; APBT_PSEL low on the next cycle.
- PRESET asserted during ACCESS of an I1 transfer -> next cycle APBT_PSEL=0, ARB_GNT=00, no PREADY to I1; a subsequent tie grants I0 first.

Source files
------------

// File: rtl/coreapb3_arbiter.sv
// Two-initiator APB3 arbiter: grants one initiator per transfer, replays a clean
// setup/access sequence on the shared target and stalls the loser with PREADY low.
module coreapb3_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ARB_MODE   = 1,
   parameter int TIMEOUT    = 0
) (
   input  logic                  PCLK,
   input  logic                  PRESET,

   input  logic                  APBI0_PSEL,
   input  logic                  APBI0_PWRITE,
   input  logic                  APBI0_PENABLE,
   input  logic [ADDR_WIDTH-1:0] APBI0_PADDR,
   input  logic [DATA_WIDTH-1:0] APBI0_PWDATA,
   output logic                  APBI0_PREADY,
   output logic                  APBI0_PSLVERR,
   output logic [DATA_WIDTH-1:0] APBI0_PRDATA,

   input  logic                  APBI1_PSEL,
   input  logic                  APBI1_PWRITE,
   input  logic                  APBI1_PENABLE,
   input  logic [ADDR_WIDTH-1:0] APBI1_PADDR,
   input  logic [DATA_WIDTH-1:0] APBI1_PWDATA,
   output logic                  APBI1_PREADY,
   output logic                  APBI1_PSLVERR,
   output logic [DATA_WIDTH-1:0] APBI1_PRDATA,

   output logic                  APBT_PSEL,
   output logic                  APBT_PWRITE,
   output logic                  APBT_PENABLE,
   output logic [ADDR_WIDTH-1:0] APBT_PADDR,
   output logic [DATA_WIDTH-1:0] APBT_PWDATA,
   input  logic                  APBT_PREADY,
   input  logic                  APBT_PSLVERR,
   input  logic [DATA_WIDTH-1:0] APBT_PRDATA,

   output logic [1:0]            ARB_GNT,
   output logic                  ARB_TIMEOUT
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam logic [15:0] WDOG_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

   state_t      state;
   logic        gnt;
   logic        last;
   logic [15:0] wcnt;

   logic        req0;
   logic        req1;
   logic        in_access;
   logic        wdog_fire;
   logic        done;
   logic        sel1;
   logic        unused_penable;

   // PSEL alone is the request so an initiator stalled in its access phase still counts.
   assign req0           = APBI0_PSEL;
   assign req1           = APBI1_PSEL;
   assign unused_penable = APBI0_PENABLE ^ APBI1_PENABLE;

   assign in_access = (state == ACCESS);
   assign wdog_fire = (TIMEOUT != 0) && in_access && !APBT_PREADY && (wcnt == WDOG_LAST);
   assign done      = in_access && (APBT_PREADY || wdog_fire);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state <= IDLE;
         gnt   <= 1'b0;
         last  <= 1'b1;
         wcnt  <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  state <= SETUP;
                  if (req0 && req1) gnt <= (ARB_MODE == 0) ? 1'b0 : ~last;
                  else              gnt <= req1;
               end
            end
            SETUP: begin
               wcnt  <= 16'd0;
               state <= ACCESS;
            end
            ACCESS: begin
               if (done) begin
                  last  <= gnt;
                  state <= IDLE;
               end else begin
                  wcnt <= wcnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Target-side address/data follow the grant; IDLE parks the mux on I0.
   assign sel1         = (state != IDLE) && gnt;
   assign APBT_PSEL    = (state != IDLE);
   assign APBT_PENABLE = in_access;
   assign APBT_PWRITE  = sel1 ? APBI1_PWRITE : APBI0_PWRITE;
   assign APBT_PADDR   = sel1 ? APBI1_PADDR  : APBI0_PADDR;
   assign APBT_PWDATA  = sel1 ? APBI1_PWDATA : APBI0_PWDATA;

   assign ARB_GNT     = (state == IDLE) ? 2'b00 : (gnt ? 2'b10 : 2'b01);
   assign ARB_TIMEOUT = wdog_fire;

   // NOTE: every output gets a default before the conditional paths, which keeps
   // this block purely combinational with no inferred latches.
   always_comb begin
      APBI0_PREADY  = 1'b0;
      APBI0_PSLVERR = 1'b0;
      APBI0_PRDATA  = '0;
      APBI1_PREADY  = 1'b0;
      APBI1_PSLVERR = 1'b0;
      APBI1_PRDATA  = '0;
      if (in_access) begin
         if (!gnt) begin
            APBI0_PREADY  = done;
            APBI0_PSLVERR = APBT_PSLVERR || wdog_fire;
            APBI0_PRDATA  = wdog_fire ? '0 : APBT_PRDATA;
         end else begin
            APBI1_PREADY  = done;
            APBI1_PSLVERR = APBT_PSLVERR || wdog_fire;
            APBI1_PRDATA  = wdog_fire ? '0 : APBT_PRDATA;
         end
      end
   end

endmodule
